// File: rtl/q_perm_pkg.sv
// Shared types, Twofish q0/q1 t-box tables and nibble helpers for the q-permutation pipeline.
package q_perm_pkg;

  typedef logic [3:0] nibble_t;
  typedef nibble_t [0:15] tbox_rom_t;

  // Entry 0 is the leftmost hex digit of each constant.
  localparam tbox_rom_t Q0_T0 = 64'h817D_6F32_0B59_ECA4;
  localparam tbox_rom_t Q0_T1 = 64'hECB8_1235_F4A6_709D;
  localparam tbox_rom_t Q0_T2 = 64'hBA5E_6D90_C8F3_2471;
  localparam tbox_rom_t Q0_T3 = 64'hD7F4_126E_9B30_85CA;
  localparam tbox_rom_t Q1_T0 = 64'h28BD_F76E_3194_0AC5;
  localparam tbox_rom_t Q1_T1 = 64'h1E2B_4C37_6DA5_F908;
  localparam tbox_rom_t Q1_T2 = 64'h4C75_169A_0ED8_2B3F;
  localparam tbox_rom_t Q1_T3 = 64'hB951_C3DE_647F_208A;

  function automatic nibble_t ror4(input nibble_t x, input logic [1:0] amount);
    logic [7:0] twice;
    twice = {x, x};
    return twice[amount +: 4];
  endfunction

  // Returns {a ^ b, a ^ ror4(b,1) ^ (a[0] << 3)}: the mixing step between t-box layers.
  function automatic logic [7:0] mix(input nibble_t a, input nibble_t b);
    return {a ^ b, a ^ ror4(b, 2'd1) ^ {a[0], 3'b000}};
  endfunction

endpackage

// File: rtl/q_half_round.sv
// One half of the q-permutation for one byte lane: round 0 is mix/T0,T1/mix, round 1 is T2,T3 only.
module q_half_round
  import q_perm_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    sel_q1,
  input  logic    round,
  output nibble_t a_out,
  output nibble_t b_out
);

  tbox_rom_t rom_a;
  tbox_rom_t rom_b;
  nibble_t   idx_a;
  nibble_t   idx_b;
  nibble_t   tab_a;
  nibble_t   tab_b;

  always_comb begin
    if (round) begin
      rom_a          = sel_q1 ? Q1_T2 : Q0_T2;
      rom_b          = sel_q1 ? Q1_T3 : Q0_T3;
      {idx_a, idx_b} = {a, b};
    end else begin
      rom_a          = sel_q1 ? Q1_T0 : Q0_T0;
      rom_b          = sel_q1 ? Q1_T1 : Q0_T1;
      {idx_a, idx_b} = mix(a, b);
    end
    tab_a          = rom_a[idx_a];
    tab_b          = rom_b[idx_b];
    {a_out, b_out} = round ? {tab_a, tab_b} : mix(tab_a, tab_b);
  end

endmodule

// File: rtl/q_perm_pipe.sv
// Multi-lane pipelined Twofish q0/q1 permutation with valid/ready flow control and full backpressure.
module q_perm_pipe
  import q_perm_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic [LANES-1:0]   in_sel_q1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  logic [4*LANES-1:0] mid_a;
  logic [4*LANES-1:0] mid_b;
  logic [4*LANES-1:0] r1_a;
  logic [4*LANES-1:0] r1_b;
  logic [LANES-1:0]   r1_sel;
  logic [8*LANES-1:0] perm;
  logic [8*LANES-1:0] out_q;
  logic               last_valid;
  logic               last_load;
  logic               feed_valid;

  genvar k;
  for (k = 0; k < LANES; k++) begin : g_lane
    q_half_round u_round0 (
      .a      (in_data[8*k+4 +: 4]),
      .b      (in_data[8*k +: 4]),
      .sel_q1 (in_sel_q1[k]),
      .round  (1'b0),
      .a_out  (mid_a[4*k +: 4]),
      .b_out  (mid_b[4*k +: 4])
    );

    // Output byte is {b4, a4}, so a4 lands in the low nibble.
    q_half_round u_round1 (
      .a      (r1_a[4*k +: 4]),
      .b      (r1_b[4*k +: 4]),
      .sel_q1 (r1_sel[k]),
      .round  (1'b1),
      .a_out  (perm[8*k +: 4]),
      .b_out  (perm[8*k+4 +: 4])
    );
  end

  assign last_load = ~last_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_valid <= 1'b0;
      out_q      <= '0;
    end else if (last_load) begin
      last_valid <= feed_valid;
      out_q      <= perm;
    end
  end

  if (STAGES == 1) begin : g_one_stage
    assign feed_valid = in_valid;
    assign r1_a       = mid_a;
    assign r1_b       = mid_b;
    assign r1_sel     = in_sel_q1;
    assign in_ready   = last_load;
    assign busy       = last_valid;
  end else begin : g_two_stage
    logic               s1_valid;
    logic               s1_load;
    logic [4*LANES-1:0] s1_a;
    logic [4*LANES-1:0] s1_b;
    logic [LANES-1:0]   s1_sel;

    // Stage 1 accepts when empty or when its beat moves on; this path is combinational from out_ready.
    assign s1_load = ~s1_valid | last_load;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_a     <= '0;
        s1_b     <= '0;
        s1_sel   <= '0;
      end else if (s1_load) begin
        s1_valid <= in_valid;
        s1_a     <= mid_a;
        s1_b     <= mid_b;
        s1_sel   <= in_sel_q1;
      end
    end

    assign feed_valid = s1_valid;
    assign r1_a       = s1_a;
    assign r1_b       = s1_b;
    assign r1_sel     = s1_sel;
    assign in_ready   = s1_load;
    assign busy       = s1_valid | last_valid;
  end

  assign out_valid = last_valid;
  assign out_data  = out_q;

endmodule
